// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath:
// FSM states, opcodes, ALU operations and mux select codes.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALRADR  = 4'd11,
      S_JALR     = 4'd12,
      S_LUI      = 4'd13
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   function automatic logic [2:0] imm_decode(input logic [6:0] op);
      logic [2:0] imm;
      case (op)
         OP_LW, OP_JALR, OP_I: imm = IMM_I;
         OP_SW:                imm = IMM_S;
         OP_B:                 imm = IMM_B;
         OP_JAL:               imm = IMM_J;
         OP_LUI:               imm = IMM_U;
         default:              imm = 3'b000;
      endcase
      return imm;
   endfunction

   // Branch condition uses the flags of the RD1 - RD2 subtraction.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero, input logic neg);
      logic taken;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = neg;
         3'b101:  taken = ~neg;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's ALUOp class and the
// instruction funct fields to the datapath ALUControl code.
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  aluop_t     aluop,
   output logic [2:0] alu_control
);

   // Select the ALU operation; op5 separates R-type (sub allowed) from I-type.
   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000: begin
                  if (op5 && funct7_5) begin
                     alu_control = ALU_SUB;
                  end else begin
                     alu_control = ALU_ADD;
                  end
               end
               3'b111:  alu_control = ALU_AND;
               3'b110:  alu_control = ALU_OR;
               3'b100:  alu_control = ALU_XOR;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I datapath: sequences each
// instruction through 3-5 states and drives every datapath select/enable.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       neg,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       illegal
);

   state_t state_r;
   state_t state_next_s;
   aluop_t aluop_s;
   logic [2:0] alu_control_s;

   // State register; reset lands in FETCH so outputs show fetch values at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   alu_decoder u_alu_decoder (
      .op5         (op[5]),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .aluop       (aluop_s),
      .alu_control (alu_control_s)
   );

   assign ALUControl = alu_control_s;
   assign ImmSrc     = imm_decode(op);

   // Next-state and per-state output decode.
   always_comb begin
      state_next_s = S_FETCH;
      PCWrite      = 1'b0;
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      ResultSrc    = RES_ALUOUT;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RD2;
      aluop_s      = ALUOP_ADD;
      illegal      = 1'b0;
      case (state_r)
         S_FETCH: begin
            IRWrite      = 1'b1;
            PCWrite      = 1'b1;
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURES;
            state_next_s = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next_s = S_MEMADR;
               OP_R:         state_next_s = S_EXECR;
               OP_I:         state_next_s = S_EXECI;
               OP_B:         state_next_s = S_BRANCH;
               OP_JAL:       state_next_s = S_JAL;
               OP_JALR:      state_next_s = S_JALRADR;
               OP_LUI:       state_next_s = S_LUI;
               default: begin
                  illegal      = 1'b1;
                  state_next_s = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            if (op == OP_LW) begin
               state_next_s = S_MEMREAD;
            end else if (op == OP_SW) begin
               state_next_s = S_MEMWRITE;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_MEMREAD: begin
            AdrSrc       = 1'b1;
            state_next_s = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc    = RES_DATA;
            RegWrite     = 1'b1;
            state_next_s = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc       = 1'b1;
            MemWrite     = 1'b1;
            state_next_s = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA      = SRCA_RD1;
            ALUSrcB      = SRCB_RD2;
            aluop_s      = ALUOP_FUNCT;
            state_next_s = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA      = SRCA_RD1;
            ALUSrcB      = SRCB_IMM;
            aluop_s      = ALUOP_FUNCT;
            state_next_s = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite     = 1'b1;
            state_next_s = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA      = SRCA_RD1;
            ALUSrcB      = SRCB_RD2;
            aluop_s      = ALUOP_SUB;
            PCWrite      = branch_taken(funct3, zero, neg);
            state_next_s = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            PCWrite      = 1'b1;
            state_next_s = S_ALUWB;
         end
         S_JALRADR: begin
            ALUSrcA      = SRCA_RD1;
            ALUSrcB      = SRCB_IMM;
            state_next_s = S_JALR;
         end
         S_JALR: begin
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            PCWrite      = 1'b1;
            state_next_s = S_ALUWB;
         end
         S_LUI: begin
            ResultSrc    = RES_IMM;
            RegWrite     = 1'b1;
            state_next_s = S_FETCH;
         end
         default: state_next_s = S_FETCH;
      endcase
   end

endmodule
